// File: rtl/viterbi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_ctrl
// Purpose  : Paces symbols into BMC/ACS, rotates survivor banks, and schedules
//            traceback/decode reads.
// Revision : 1.0
// ============================================================================
module viterbi_ctrl #(
   parameter int BLOCK_LEN = 16,
   parameter int ADDR_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              in_valid_i,
   input  logic              flush_i,
   output logic              in_ready_o,
   output logic              acs_init_o,
   output logic              pad_o,
   output logic              wr_en_o,
   output logic [1:0]        wr_bank_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic              tb_start_o,
   output logic [1:0]        tb_bank_o,
   output logic [1:0]        dec_bank_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   output logic              dec_valid_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int CNT_W    = ADDR_W + 2;
   localparam int FILL_MAX = 2 * BLOCK_LEN;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_RUN   = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   state_t            state_q;
   logic [1:0]        wr_bank_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [CNT_W-1:0]  fill_cnt_q;
   logic [ADDR_W:0]   flush_cnt_q;
   logic              first_q;
   logic              done_q;

   logic              w_in_ready;
   logic              w_step;
   logic              w_fill_full;
   logic [CNT_W-1:0]  fill_cnt_d;

   always_comb begin
      w_in_ready  = (state_q == S_FILL) || (state_q == S_RUN);
      w_step      = (in_valid_i && w_in_ready) || (state_q == S_FLUSH);
      w_fill_full = (fill_cnt_q == CNT_W'(FILL_MAX));
      fill_cnt_d  = (w_step && !w_fill_full) ? fill_cnt_q + CNT_W'(1) : fill_cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wr_bank_q   <= 2'd0;
         wr_addr_q   <= '0;
         fill_cnt_q  <= '0;
         flush_cnt_q <= '0;
         first_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // start outranks a coincident flush, which is simply dropped
               if (start_i) begin
                  state_q     <= S_FILL;
                  wr_bank_q   <= 2'd0;
                  wr_addr_q   <= '0;
                  fill_cnt_q  <= '0;
                  flush_cnt_q <= '0;
                  first_q     <= 1'b1;
               end
            end
            S_FILL, S_RUN: begin
               if (flush_i) begin
                  state_q     <= S_FLUSH;
                  flush_cnt_q <= '0;
               end else if ((state_q == S_FILL) && (fill_cnt_d == CNT_W'(FILL_MAX))) begin
                  state_q <= S_RUN;
               end
            end
            S_FLUSH: begin
               flush_cnt_q <= flush_cnt_q + (ADDR_W+1)'(1);
               if (flush_cnt_q == (ADDR_W+1)'(FILL_MAX - 1)) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase

         // Never true in IDLE, so it cannot collide with the counter clear above
         if (w_step) begin
            wr_addr_q  <= wr_addr_q + ADDR_W'(1);
            fill_cnt_q <= fill_cnt_d;
            first_q    <= 1'b0;
            if (wr_addr_q == ADDR_W'(BLOCK_LEN - 1)) begin
               wr_bank_q <= wr_bank_q + 2'd1;
            end
         end
      end
   end

   always_comb begin
      in_ready_o  = w_in_ready;
      acs_init_o  = w_step && first_q;
      pad_o       = (state_q == S_FLUSH);
      wr_en_o     = w_step;
      wr_bank_o   = wr_bank_q;
      wr_addr_o   = wr_addr_q;
      tb_start_o  = w_step && (wr_addr_q == '0) && w_fill_full;
      tb_bank_o   = wr_bank_q - 2'd1;
      dec_bank_o  = wr_bank_q - 2'd2;
      rd_addr_o   = ADDR_W'(BLOCK_LEN - 1) - wr_addr_q;
      dec_valid_o = w_step && w_fill_full;
      busy_o      = (state_q != S_IDLE);
      done_o      = done_q;
   end

endmodule
`default_nettype wire

// File: doc/viterbi_ctrl.md
# viterbi_ctrl

Sequencing controller for the Viterbi decoder datapath. It paces received symbol pairs into the branch-metric and ACS stages, and generates write addresses for survivor-decision memory across four rotating banks. It also schedules traceback and decode reads on the two oldest complete banks. It sits between the symbol source and the BMC/ACS/survivor-memory/traceback blocks and drives all of their control inputs.

## Interface
- BLOCK_LEN, 16: steps per survivor-memory bank; power of two, ≥ 4
- ADDR_W, 4: log2(BLOCK_LEN)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse: begin a new decode stream
- in_valid  in  1  rx_pair presented to BMCs this cycle
- flush  in  1  pulse: end of stream, drain the trellis
- in_ready  out  1  controller accepts in_valid this cycle
- acs_init  out  1  ACS loads initial path metrics instead of accumulating
- pad  out  1  upstream substitutes rx_pair = 2'b00 (tail symbols)
- wr_en  out  1  write ACS decisions at wr_bank/wr_addr
- wr_bank  out  2  bank being written
- wr_addr  out  ADDR_W  write address
- tb_start  out  1  traceback unit restarts from best state
- tb_bank  out  2  bank being traced back
- dec_bank  out  2  bank being decoded
- rd_addr  out  ADDR_W  read address for tb_bank and dec_bank
- dec_valid  out  1  decoded bit valid this cycle
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at end of flush

## Operation
- States: IDLE, FILL, RUN, FLUSH.
- step = (in_valid & in_ready) | (state == FLUSH).
- in_ready = state ∈ {FILL, RUN}.
- IDLE→FILL on start. Counters clear. acs_init is high for the first step after start only.
- FILL→RUN when fill_cnt reaches 2*BLOCK_LEN.
  - fill_cnt: total steps since start, saturating at 2*BLOCK_LEN.
- FILL or RUN→FLUSH on flush. Flush is a one-cycle pulse.
- FLUSH lasts exactly 2*BLOCK_LEN steps, one per cycle.
  - pad = 1 throughout FLUSH.
  - After the final step: done = 1 for one cycle, then →IDLE.
- start outside IDLE is ignored. flush in IDLE or FLUSH is ignored. start and flush in the same cycle in IDLE: start wins, flush is dropped.
- Addressing:
  - wr_en = step.
  - wr_addr increments on every step. When it wraps from BLOCK_LEN-1 to 0, wr_bank increments mod 4.
  - rd_addr = BLOCK_LEN-1-wr_addr, so reads run backward.
  - tb_bank = wr_bank-1 mod 4.
  - dec_bank = wr_bank-2 mod 4.
- tb_start = step & (wr_addr == 0) & (fill_cnt == 2*BLOCK_LEN).
- dec_valid = step & (fill_cnt == 2*BLOCK_LEN). This also applies during FLUSH entered from FILL, once saturated.

## Timing
- Reset values:
  - state = IDLE.
  - wr_bank, wr_addr, fill_cnt and the flush counter = 0.
  - All 1-bit outputs = 0.
  - rd_addr = BLOCK_LEN-1, tb_bank = 3, dec_bank = 2.
- Counters and state are registered. All outputs are combinational from registered state plus in_valid, so wr_en and dec_valid apply in the same cycle as in_valid.
- Address and bank outputs describe the current step and advance on the clock edge after it.
- First dec_valid occurs on step 2*BLOCK_LEN+1 after start, which is step index 2*BLOCK_LEN counting from 0.
- rst asserted mid-stream returns the block to IDLE immediately. No done pulse is generated.

## Test plan
- Reset, then start, then 32 consecutive in_valid with BLOCK_LEN=16:
  - acs_init only on step 0.
  - wr_bank goes 0→1 after step 15.
  - No dec_valid and no tb_start during these 32 steps.
  - State is RUN after step 31.
- Continue with step 32:
  - tb_start = 1, wr_bank = 2, wr_addr = 0, rd_addr = 15, tb_bank = 1, dec_bank = 0, dec_valid = 1.
- Gapped in_valid (1 of every 3 cycles):
  - Addresses change only after valid cycles.
  - in_ready is held high.
  - wr_en mirrors in_valid.
- Bank wrap after 64 steps:
  - wr_bank 3→0, tb_bank = 3, dec_bank = 2.
- flush in RUN at wr_addr = 5:
  - pad and wr_en high for exactly 32 cycles, in_ready = 0, dec_valid high throughout.
  - done pulses once, then busy = 0.
- Edge cases:
  - start and flush together in IDLE → FILL.
  - rst asserted in FLUSH → all outputs at their reset values before the next clock edge, and done never pulses.
